// File: rtl/event_stamper_if.sv
// Head-of-queue event bus between the stamper (master) and a downstream monitor (slave).
interface event_stamper_if #(
    parameter int DW  = 64,
    parameter int TSW = 64
);
    logic                  ev_valid;
    logic                  ev_ready;
    logic [TSW-1:0]        ev_tag;
    logic signed [DW-1:0]  ev_input_0;
    logic signed [DW-1:0]  ev_input_1;
    logic                  ev_new_0;
    logic                  ev_new_1;

    modport master (
        output ev_valid, ev_tag, ev_input_0, ev_input_1, ev_new_0, ev_new_1,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_tag, ev_input_0, ev_input_1, ev_new_0, ev_new_1,
        output ev_ready
    );
endinterface

// File: rtl/event_stamper.sv
// Timestamps strobed input samples and queues them in a small FIFO; full-FIFO
// captures without a simultaneous pop are dropped and counted.
module event_stamper #(
    parameter int DEPTH = 4,
    parameter int DW    = 64,
    parameter int TSW   = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic signed [DW-1:0]       input_0,
    input  logic signed [DW-1:0]       input_1,
    input  logic                       new_input_0,
    input  logic                       new_input_1,
    event_stamper_if.master            ev,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [15:0]                drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = TSW + 2 * DW + 2;

    logic [TSW-1:0] ts_q,        ts_d;
    logic [AW-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [LW-1:0]  level_q,     level_d;
    logic           overflow_q,  overflow_d;
    logic [15:0]    drop_cnt_q,  drop_cnt_d;

    logic [RW-1:0]  mem_q [DEPTH];
    logic [RW-1:0]  head;
    logic [RW-1:0]  wr_rec;

    logic [1:0]     strobe;
    logic [DW-1:0]  lane_in  [2];
    logic [DW-1:0]  lane_val [2];

    logic capture, pop, push, drop, full, valid;

    assign strobe     = {new_input_1, new_input_0};
    assign lane_in[0] = input_0;
    assign lane_in[1] = input_1;

    // A lane whose strobe is low is recorded as zero so stale values never leak out.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_val[gi] = strobe[gi] ? lane_in[gi] : '0;
        end
    endgenerate

    assign wr_rec  = {ts_q, lane_val[0], lane_val[1], strobe[0], strobe[1]};

    assign valid   = (level_q != '0);
    assign full    = (level_q == LW'(DEPTH));
    assign capture = en & (|strobe);
    assign pop     = valid & ev.ev_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push    = capture & (~full | pop);
    assign drop    = capture & full & ~pop;

    always_comb begin
        ts_d        = en ? ts_q + TSW'(1) : ts_q;
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d     = level_q + LW'(push) - LW'(pop);
        overflow_d  = overflow_q | drop;
        drop_cnt_d  = drop_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: contents are only visible while level is non-zero.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= wr_rec;
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign ev.ev_valid   = valid;
    assign ev.ev_tag     = valid ? head[RW-1 -: TSW]   : '0;
    assign ev.ev_input_0 = valid ? head[2*DW+1 -: DW]  : '0;
    assign ev.ev_input_1 = valid ? head[DW+1 -: DW]    : '0;
    assign ev.ev_new_0   = valid ? head[1]             : 1'b0;
    assign ev.ev_new_1   = valid ? head[0]             : 1'b0;

    assign level    = level_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
endmodule
